inverse_factorial_seq: RTL and testbench

- Sequential inverse of the combinational factorial block.
- Given an OUT-bit value V, iteratively finds the largest k such that k! <= V, and flags whether V is exactly k!.
- Uses one multiply per cycle and a start / valid-ready handshake.
- Sits downstream of factorial producers in the math-concepts library; used to decode factorial-encoded values back to their index.

---
 rtl/inverse_factorial_seq_if.sv | 37 +++
 rtl/inverse_factorial_seq.sv | 104 ++++++++++
 tb/tb_inverse_factorial_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/inverse_factorial_seq_if.sv
// rtl/inverse_factorial_seq_if.sv - start/value request and result handshake bundle for inverse_factorial_seq
// fact_floor exists only when INVFACT_FLOOR_OUT_EN is defined.
interface inverse_factorial_seq_if #(
    parameter int N   = 4,
    parameter int OUT = 32
);
    logic           start;
    logic [OUT-1:0] value;
    logic           busy;
    logic           res_valid;
    logic           res_ready;
    logic [N-1:0]   k_out;
    logic           exact;
`ifdef INVFACT_FLOOR_OUT_EN
    logic [OUT-1:0] fact_floor;
`endif

`ifdef INVFACT_FLOOR_OUT_EN
    modport master (
        output start, value, res_ready,
        input  busy, res_valid, k_out, exact, fact_floor
    );
    modport slave (
        input  start, value, res_ready,
        output busy, res_valid, k_out, exact, fact_floor
    );
`else
    modport master (
        output start, value, res_ready,
        input  busy, res_valid, k_out, exact
    );
    modport slave (
        input  start, value, res_ready,
        output busy, res_valid, k_out, exact
    );
`endif
endinterface

// File: rtl/inverse_factorial_seq.sv
// rtl/inverse_factorial_seq.sv - finds largest k with k! <= V, one multiply per cycle
// Optional macro INVFACT_FLOOR_OUT_EN adds fact_floor = k_out!.
module inverse_factorial_seq #(
    parameter int N   = 4,
    parameter int OUT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inverse_factorial_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam int W = OUT + N;

    state_t         r_state, w_state_nxt;
    logic [OUT-1:0] r_prod, w_prod_nxt;
    logic [N-1:0]   r_cnt, w_cnt_nxt;
    logic [OUT-1:0] r_vreg, w_vreg_nxt;
    logic [N-1:0]   r_k, w_k_nxt;
    logic           r_exact, w_exact_nxt;
    logic [OUT-1:0] r_fact, w_fact_nxt;

    logic [W-1:0]   w_nxt;
    logic           w_term;

    // Widened before the increment so cnt = 2^N-1 still yields 2^N.
    assign w_nxt  = W'(r_prod) * (W'(r_cnt) + W'(1));
    assign w_term = (w_nxt > W'(r_vreg)) || (|w_nxt[W-1:OUT]) || (r_cnt == {N{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prod_nxt  = r_prod;
        w_cnt_nxt   = r_cnt;
        w_vreg_nxt  = r_vreg;
        w_k_nxt     = r_k;
        w_exact_nxt = r_exact;
        w_fact_nxt  = r_fact;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_vreg_nxt  = bus.value;
                    w_prod_nxt  = {{(OUT-1){1'b0}}, 1'b1};
                    w_cnt_nxt   = {{(N-1){1'b0}}, 1'b1};
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                // vreg is constant during CALC, so this only fires on the first cycle.
                if (r_vreg == '0) begin
                    w_k_nxt     = '0;
                    w_exact_nxt = 1'b0;
                    w_fact_nxt  = r_prod;
                    w_state_nxt = S_DONE;
                end else if (w_term) begin
                    w_k_nxt     = r_cnt;
                    w_exact_nxt = (r_prod == r_vreg);
                    w_fact_nxt  = r_prod;
                    w_state_nxt = S_DONE;
                end else begin
                    w_prod_nxt = w_nxt[OUT-1:0];
                    w_cnt_nxt  = r_cnt + N'(1);
                end
            end
            S_DONE: begin
                if (bus.res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod  <= {{(OUT-1){1'b0}}, 1'b1};
            r_cnt   <= {{(N-1){1'b0}}, 1'b1};
            r_vreg  <= '0;
            r_k     <= '0;
            r_exact <= 1'b0;
            r_fact  <= {{(OUT-1){1'b0}}, 1'b1};
        end else begin
            r_prod  <= w_prod_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vreg  <= w_vreg_nxt;
            r_k     <= w_k_nxt;
            r_exact <= w_exact_nxt;
            r_fact  <= w_fact_nxt;
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.k_out     = r_k;
    assign bus.exact     = r_exact;
`ifdef INVFACT_FLOOR_OUT_EN
    assign bus.fact_floor = r_fact;
`else
    logic w_fact_unused;
    assign w_fact_unused = ^r_fact;
`endif
endmodule

// File: tb/tb_inverse_factorial_seq.sv
// tb/tb_inverse_factorial_seq.sv - directed self-checking bench for inverse_factorial_seq
module tb_inverse_factorial_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    inverse_factorial_seq_if #(.N(4), .OUT(32)) bus ();
    inverse_factorial_seq #(.N(4), .OUT(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts V, counts rising edges from the sampling edge to res_valid, checks result and fact_floor.
    task automatic launch(input string tag, input logic [31:0] v, input int ek, input int eex,
                          input int elat, input logic [31:0] efact);
        int lat;
        bus.start = 1'b1;
        bus.value = v;
        tick();
        bus.start = 1'b0;
        bus.value = 32'hDEAD_BEEF;
        lat = 1;
        while (bus.res_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_k"}, 32'(bus.k_out), ek);
        check({tag, "_exact"}, 32'(bus.exact), eex);
`ifdef INVFACT_FLOOR_OUT_EN
        check({tag, "_fact"}, bus.fact_floor, efact);
`else
        if (efact == 32'hFFFF_FFFF) $display("note: unexpected sentinel");
`endif
    endtask

    task automatic accept(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, "_rv_drop"}, 32'(bus.res_valid), 0);
        check({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.value     = '0;
        bus.res_ready = 1'b0;
        #12;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_rv", 32'(bus.res_valid), 0);
        check("rst_k", 32'(bus.k_out), 0);
        check("rst_exact", 32'(bus.exact), 0);
`ifdef INVFACT_FLOOR_OUT_EN
        check("rst_fact", bus.fact_floor, 1);
`endif
        rst_n = 1'b1;
        tick();

        launch("v24", 32'd24, 4, 1, 5, 32'd24);
        accept("v24");
        check("v24_hold_k", 32'(bus.k_out), 4);
        launch("v25", 32'd25, 4, 0, 5, 32'd24);
        accept("v25");
        launch("v1", 32'd1, 1, 1, 2, 32'd1);
        accept("v1");
        launch("v0", 32'd0, 0, 0, 2, 32'd1);
        accept("v0");
        launch("vmax", 32'hFFFF_FFFF, 12, 0, 13, 32'd479001600);
        accept("vmax");
        launch("v12f", 32'd479001600, 12, 1, 13, 32'd479001600);

        // Backpressure: hold DONE for 10 cycles, poke start with V=6 which must be ignored.
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.start = 1'b1;
                bus.value = 32'd6;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        check("bp_rv", 32'(bus.res_valid), 1);
        check("bp_k", 32'(bus.k_out), 12);
        check("bp_exact", 32'(bus.exact), 1);
        // start coinciding with the DONE->IDLE transfer must not launch a job.
        bus.start     = 1'b1;
        bus.value     = 32'd6;
        bus.res_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        check("bp_rv_drop", 32'(bus.res_valid), 0);
        check("bp_idle", 32'(bus.busy), 0);
        tick();
        check("bp_no_launch", 32'(bus.busy), 0);
        check("bp_k_kept", 32'(bus.k_out), 12);

        // Reset asserted during the third CALC cycle.
        bus.start = 1'b1;
        bus.value = 32'd479001600;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("mid_busy_pre", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(bus.busy), 0);
        check("mid_rv", 32'(bus.res_valid), 0);
        check("mid_k", 32'(bus.k_out), 0);
        check("mid_exact", 32'(bus.exact), 0);
        tick();
        rst_n = 1'b1;
        tick();
        launch("v120", 32'd120, 5, 1, 6, 32'd120);
        accept("v120");

        launch("v720", 32'd720, 6, 1, 7, 32'd720);
        accept("v720");
        launch("v719", 32'd719, 5, 0, 6, 32'd120);
        accept("v719");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
